// File: rtl/fetch_decode_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_decode_stage_if
// Bundles the front-end signals exchanged between the hazard controller /
// instruction memory side (master) and the fetch/decode stage (slave).
//
// Signals (direction as seen by the slave):
//   instr_in       in   INSTR_W  instruction memory data for address pc
//   branch_target  in   PC_W     redirect address, meaningful with flush_fetch
//   flush_fetch    in   1        kill fetched instruction, redirect PC
//   flush_decode   in   1        kill instruction in decode (bubble to EX)
//   stall_fetch    in   1        hold PC
//   stall_decode   in   1        hold IF/ID, bubble to EX
//   pc_write       in   1        PC write enable
//   pc             out  PC_W     instruction memory address
//   ifid_instr     out  INSTR_W  IF/ID instruction register
//   ifid_pc_next   out  PC_W     IF/ID copy of pc+1
//   ifid_valid     out  1        IF/ID holds a live instruction
//   r_dest_fetch   out  3        ifid_instr[10:8]
//   r_src_fetch    out  3        ifid_instr[7:5]
//   ex_bubble      out  1        ID/EX must load NOP this cycle
//   stall_cnt      out  CNT_W    saturating stall-cycle counter
//   flush_cnt      out  CNT_W    saturating flush-cycle counter
// -----------------------------------------------------------------------------
interface fetch_decode_stage_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) ();

  logic [INSTR_W-1:0] instr_in;
  logic [PC_W-1:0]    branch_target;
  logic               flush_fetch;
  logic               flush_decode;
  logic               stall_fetch;
  logic               stall_decode;
  logic               pc_write;

  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc_next;
  logic               ifid_valid;
  logic [2:0]         r_dest_fetch;
  logic [2:0]         r_src_fetch;
  logic               ex_bubble;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  modport master (
    output instr_in, branch_target, flush_fetch, flush_decode,
           stall_fetch, stall_decode, pc_write,
    input  pc, ifid_instr, ifid_pc_next, ifid_valid, r_dest_fetch,
           r_src_fetch, ex_bubble, stall_cnt, flush_cnt
  );

  modport slave (
    input  instr_in, branch_target, flush_fetch, flush_decode,
           stall_fetch, stall_decode, pc_write,
    output pc, ifid_instr, ifid_pc_next, ifid_valid, r_dest_fetch,
           r_src_fetch, ex_bubble, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/fetch_decode_stage.sv
// -----------------------------------------------------------------------------
// fetch_decode_stage
// Owns the PC and the IF/ID register. Each cycle the front end either
// advances, holds (stall) or is redirected/killed (flush) according to the
// hazard controller's controls, with priority flush > stall > advance.
// The ID/EX bubble request is produced combinationally so the execute stage
// can load a NOP in the same cycle the hazard is signalled.
//
// Ports:
//   clk    in  1  clock, rising edge
//   rst_n  in  1  asynchronous reset, active-low
//   bus    fetch_decode_stage_if.slave  controls in, PC / IF/ID / stats out
// -----------------------------------------------------------------------------
module fetch_decode_stage #(
  parameter int                 PC_W     = 16,
  parameter int                 INSTR_W  = 16,
  parameter logic [PC_W-1:0]    RESET_PC = {PC_W{1'b0}},
  parameter logic [INSTR_W-1:0] NOP      = {INSTR_W{1'b0}},
  parameter int                 CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fetch_decode_stage_if.slave        bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACT_ADV   = 2'd0,
    ACT_STALL = 2'd1,
    ACT_FLUSH = 2'd2,
    ACT_IDLE  = 2'd3
  } act_t;

  state_t             state_r;
  state_t             state_nxt_s;
  act_t               act_s;

  logic [PC_W-1:0]    pc_r;
  logic [INSTR_W-1:0] ifid_instr_r;
  logic [PC_W-1:0]    ifid_pc_next_r;
  logic               ifid_valid_r;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic [CNT_W-1:0]   flush_cnt_r;

  // Undriven (X/Z) controls must read as inactive, hence the case equality.
  logic ff_s, fd_s, sf_s, sd_s, pw_s;
  logic flush_any_s, stall_any_s, stall_cnt_inc_s;
  logic [PC_W-1:0] pc_plus1_s;

  assign ff_s = (bus.flush_fetch  === 1'b1);
  assign fd_s = (bus.flush_decode === 1'b1);
  assign sf_s = (bus.stall_fetch  === 1'b1);
  assign sd_s = (bus.stall_decode === 1'b1);
  assign pw_s = (bus.pc_write     === 1'b1);

  assign flush_any_s = ff_s | fd_s;
  // A missing pc_write holds the front end but is not a counted stall.
  assign stall_any_s     = sf_s | sd_s | ~pw_s;
  assign stall_cnt_inc_s = sf_s | sd_s;
  assign pc_plus1_s      = pc_r + {{(PC_W-1){1'b0}}, 1'b1};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-cycle action selection (flush > stall > advance).
  always_comb begin
    state_nxt_s = state_r;
    act_s       = ACT_IDLE;
    case (state_r)
      ST_BOOT: begin
        // First fetch after reset ignores the hazard controller.
        state_nxt_s = ST_RUN;
        act_s       = ACT_ADV;
      end
      ST_RUN, ST_HOLD: begin
        if (flush_any_s) begin
          state_nxt_s = ST_RUN;
          act_s       = ACT_FLUSH;
        end else if (stall_any_s) begin
          state_nxt_s = ST_HOLD;
          act_s       = ACT_STALL;
        end else begin
          state_nxt_s = ST_RUN;
          act_s       = ACT_ADV;
        end
      end
      default: begin
        state_nxt_s = ST_BOOT;
        act_s       = ACT_IDLE;
      end
    endcase
  end

  // PC and IF/ID register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r           <= RESET_PC;
      ifid_instr_r   <= NOP;
      ifid_pc_next_r <= {PC_W{1'b0}};
      ifid_valid_r   <= 1'b0;
    end else begin
      case (act_s)
        ACT_ADV: begin
          pc_r           <= pc_plus1_s;
          ifid_instr_r   <= bus.instr_in;
          ifid_pc_next_r <= pc_plus1_s;
          ifid_valid_r   <= 1'b1;
        end
        ACT_FLUSH: begin
          // A decode-only flush kills IF/ID but leaves the PC in place.
          if (ff_s) begin
            pc_r <= bus.branch_target;
          end else begin
            pc_r <= pc_r;
          end
          ifid_instr_r   <= NOP;
          ifid_pc_next_r <= {PC_W{1'b0}};
          ifid_valid_r   <= 1'b0;
        end
        default: begin
          pc_r           <= pc_r;
          ifid_instr_r   <= ifid_instr_r;
          ifid_pc_next_r <= ifid_pc_next_r;
          ifid_valid_r   <= ifid_valid_r;
        end
      endcase
    end
  end

  // Saturating stall/flush statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if ((act_s == ACT_STALL) && stall_cnt_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if ((act_s == ACT_FLUSH) && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign bus.pc           = pc_r;
  assign bus.ifid_instr   = ifid_instr_r;
  assign bus.ifid_pc_next = ifid_pc_next_r;
  assign bus.ifid_valid   = ifid_valid_r;
  assign bus.r_dest_fetch = ifid_instr_r[10:8];
  assign bus.r_src_fetch  = ifid_instr_r[7:5];
  assign bus.stall_cnt    = stall_cnt_r;
  assign bus.flush_cnt    = flush_cnt_r;
  // Same-cycle bubble request; also asserted throughout reset (IF/ID empty).
  assign bus.ex_bubble    = fd_s | sd_s | ~ifid_valid_r;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode_stage
// Table of {controls, expected state after the edge} records applied one per
// clock; each record is queued as the expectation when driven and popped and
// compared once the edge has happened. Hand-written sequences cover the
// asynchronous mid-stream reset and counter saturation.
// -----------------------------------------------------------------------------
module tb_fetch_decode_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fetch_decode_stage_if #(.PC_W(16), .INSTR_W(16), .CNT_W(16)) bus ();

  fetch_decode_stage #(
    .PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .NOP(16'h0000), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a fixed function of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd7) ^ 16'hA5C3;
  endfunction

  assign bus.instr_in = mem_word(bus.pc);

  typedef struct {
    logic        ff, fd, sf, sd, pw;
    logic [15:0] bt;
    logic [15:0] e_pc;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_pcn;
    logic        chk_pcn;
    logic [15:0] e_scnt;
    logic [15:0] e_fcnt;
    logic        e_bub;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic ff, fd, sf, sd, pw, input logic [15:0] bt,
                              input logic [15:0] e_pc, input logic e_valid,
                              input logic [15:0] e_instr, input logic [15:0] e_pcn,
                              input logic chk_pcn, input logic [15:0] e_scnt,
                              input logic [15:0] e_fcnt, input logic e_bub);
    vec_t v;
    v.ff = ff; v.fd = fd; v.sf = sf; v.sd = sd; v.pw = pw; v.bt = bt;
    v.e_pc = e_pc; v.e_valid = e_valid; v.e_instr = e_instr; v.e_pcn = e_pcn;
    v.chk_pcn = chk_pcn; v.e_scnt = e_scnt; v.e_fcnt = e_fcnt; v.e_bub = e_bub;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ff, fd, sf, sd, pw, input logic [15:0] bt);
    bus.flush_fetch   = ff;
    bus.flush_decode  = fd;
    bus.stall_fetch   = sf;
    bus.stall_decode  = sd;
    bus.pc_write      = pw;
    bus.branch_target = bt;
  endtask

  task automatic compare_vec(input vec_t e, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, ".pc"},         {16'h0, bus.pc},         {16'h0, e.e_pc});
    chk({tag, ".valid"},      {31'h0, bus.ifid_valid}, {31'h0, e.e_valid});
    chk({tag, ".instr"},      {16'h0, bus.ifid_instr}, {16'h0, e.e_instr});
    chk({tag, ".r_dest"},     {29'h0, bus.r_dest_fetch}, {29'h0, e.e_instr[10:8]});
    chk({tag, ".r_src"},      {29'h0, bus.r_src_fetch},  {29'h0, e.e_instr[7:5]});
    if (e.chk_pcn) begin
      chk({tag, ".pc_next"},  {16'h0, bus.ifid_pc_next}, {16'h0, e.e_pcn});
    end
    chk({tag, ".stall_cnt"},  {16'h0, bus.stall_cnt},  {16'h0, e.e_scnt});
    chk({tag, ".flush_cnt"},  {16'h0, bus.flush_cnt},  {16'h0, e.e_fcnt});
    chk({tag, ".ex_bubble"},  {31'h0, bus.ex_bubble},  {31'h0, e.e_bub});
  endtask

  initial begin
    vec_t e;
    n_checks = 0;
    n_fail   = 0;

    //          ff    fd    sf    sd    pw    bt        pc      vld  instr              pcn     chk  scnt    fcnt  bub
    // Boot edge: stall inputs ignored, but ex_bubble follows stall_decode.
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b1, mem_word(16'h0000), 16'h0001, 1'b1, 16'd0, 16'd0, 1'b1));
    // Straight-line fetch.
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 1'b1, mem_word(16'h0001), 16'h0002, 1'b1, 16'd0, 16'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0003, 1'b1, mem_word(16'h0002), 16'h0003, 1'b1, 16'd0, 16'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0004, 1'b1, mem_word(16'h0003), 16'h0004, 1'b1, 16'd0, 16'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0005, 1'b1, mem_word(16'h0004), 16'h0005, 1'b1, 16'd0, 16'd0, 1'b0));
    // Load-use stall at pc=5, then resume.
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0005, 1'b1, mem_word(16'h0004), 16'h0005, 1'b1, 16'd1, 16'd0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0006, 1'b1, mem_word(16'h0005), 16'h0006, 1'b1, 16'd1, 16'd0, 1'b0));
    // pc_write low: hold without counting.
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0006, 1'b1, mem_word(16'h0005), 16'h0006, 1'b1, 16'd1, 16'd0, 1'b0));
    // stall_decode alone holds PC too; stall_fetch alone.
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0006, 1'b1, mem_word(16'h0005), 16'h0006, 1'b1, 16'd2, 16'd0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0006, 1'b1, mem_word(16'h0005), 16'h0006, 1'b1, 16'd3, 16'd0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0007, 1'b1, mem_word(16'h0006), 16'h0007, 1'b1, 16'd3, 16'd0, 1'b0));
    // Branch with concurrent stall: flush wins, stall not counted.
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0040, 1'b0, 16'h0000,          16'h0000, 1'b0, 16'd3, 16'd1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0041, 1'b1, mem_word(16'h0040), 16'h0041, 1'b1, 16'd3, 16'd1, 1'b0));
    // Decode-only flush keeps the PC.
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0041, 1'b0, 16'h0000,          16'h0000, 1'b0, 16'd3, 16'd2, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0042, 1'b1, mem_word(16'h0041), 16'h0042, 1'b1, 16'd3, 16'd2, 1'b0));
    // Redirect to top of address space, then wrap.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000,          16'h0000, 1'b0, 16'd3, 16'd3, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, mem_word(16'hFFFF), 16'h0000, 1'b1, 16'd3, 16'd3, 1'b0));
    // X on stall_fetch reads as inactive.
    vecs.push_back(mk(1'b0, 1'b0, 1'bx, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b1, mem_word(16'h0000), 16'h0001, 1'b1, 16'd3, 16'd3, 1'b0));
    // Flush arriving while in HOLD.
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b1, mem_word(16'h0000), 16'h0001, 1'b1, 16'd4, 16'd3, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h0020, 1'b0, 16'h0000,          16'h0000, 1'b0, 16'd4, 16'd4, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0021, 1'b1, mem_word(16'h0020), 16'h0021, 1'b1, 16'd4, 16'd4, 1'b0));
    // X on flush_decode reads as inactive (advance, no bubble).
    vecs.push_back(mk(1'b0, 1'bx, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0022, 1'b1, mem_word(16'h0021), 16'h0022, 1'b1, 16'd4, 16'd4, 1'b0));

    // Power-on reset.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    #12;
    chk("rst.pc",        {16'h0, bus.pc},         32'h0);
    chk("rst.valid",     {31'h0, bus.ifid_valid}, 32'h0);
    chk("rst.instr",     {16'h0, bus.ifid_instr}, 32'h0);
    chk("rst.ex_bubble", {31'h0, bus.ex_bubble},  32'h1);
    chk("rst.stall_cnt", {16'h0, bus.stall_cnt},  32'h0);
    rst_n = 1'b1;

    // Table: drive, queue the expectation, let the edge happen, compare.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ff, vecs[i].fd, vecs[i].sf, vecs[i].sd, vecs[i].pw, vecs[i].bt);
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      compare_vec(e, i);
    end

    // Asynchronous reset mid-stream, checked before any clock edge.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.pc",        {16'h0, bus.pc},         32'h0);
    chk("arst.valid",     {31'h0, bus.ifid_valid}, 32'h0);
    chk("arst.ex_bubble", {31'h0, bus.ex_bubble},  32'h1);
    chk("arst.flush_cnt", {16'h0, bus.flush_cnt},  32'h0);
    chk("arst.stall_cnt", {16'h0, bus.stall_cnt},  32'h0);
    #1;
    rst_n = 1'b1;

    // Saturation: boot edge, then continuous stall.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    @(posedge clk);
    for (int c = 0; c < 65534; c++) begin
      @(posedge clk);
    end
    #1;
    chk("sat.pre",  {16'h0, bus.stall_cnt}, 32'h0000FFFE);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
    end
    #1;
    chk("sat.hold", {16'h0, bus.stall_cnt}, 32'h0000FFFF);
    chk("sat.pc",   {16'h0, bus.pc},        32'h00000001);
    chk("sat.fcnt", {16'h0, bus.flush_cnt}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
